// File: rtl/risky_dmem_responder_if.sv
// Load/store port between the risky core and its data-memory responder:
// a valid/ready request channel and a valid/ready response channel.
interface risky_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/risky_dmem_responder.sv
// Data-memory responder for the risky core: one request at a time, committed
// WAIT_STATES cycles after accept, result held until the core takes it.
module risky_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    risky_dmem_responder_if.slave        bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BASE_33   = {1'b0, BASE_ADDR};
    localparam logic [32:0] END_33    = BASE_33 + (33'(DEPTH_WORDS) * 33'd4);
    localparam bit          NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned, below the window, or past its last word (no wrap-around).
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} < BASE_33) ||
               ({1'b0, addr} >= END_33);
    endfunction

    state_t      state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        accept_s, commit_s, done_s;
    logic        src_we_s;
    logic [31:0] src_addr_s;
    logic [31:0] src_wdata_s;
    logic [3:0]  src_be_s;
    logic        err_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0] rd_word_s;
    logic        mem_wr_s;

    logic [31:0] mem_r [DEPTH_WORDS];

    // Next-state and handshake decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        commit_s     = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (NO_WAIT) begin
                        state_next_s = ST_RESP;
                        commit_s     = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = WAIT_INIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                    commit_s     = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next_s = ST_IDLE;
                    done_s       = 1'b1;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // With no wait states the commit edge is the accept edge, so evaluate the live bus.
    always_comb begin
        if (state_r == ST_IDLE) begin
            src_we_s    = bus.req_we;
            src_addr_s  = bus.req_addr;
            src_wdata_s = bus.req_wdata;
            src_be_s    = bus.req_be;
        end else begin
            src_we_s    = we_r;
            src_addr_s  = addr_r;
            src_wdata_s = wdata_r;
            src_be_s    = be_r;
        end
    end

    // BASE_ADDR is aligned to the window size, so in-range addresses index by their low bits.
    always_comb begin
        err_s     = addr_err(src_addr_s);
        idx_s     = src_addr_s[IDX_W+1:2];
        rd_word_s = mem_r[idx_s];
        mem_wr_s  = commit_s && src_we_s && !err_s && rst_n;
    end

    // Word array: byte-lane writes on the commit edge only, contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (src_be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= src_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // FSM state, request latch and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            be_r        <= 4'h0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
            if (accept_s) begin
                we_r    <= bus.req_we;
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
                be_r    <= bus.req_be;
            end
            if (commit_s) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= err_s;
                rsp_rdata_r <= (!err_s && !src_we_s) ? rd_word_s : 32'h0000_0000;
            end else if (done_s) begin
                rsp_valid_r <= 1'b0;
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_risky_dmem_responder.sv
// Directed bench for risky_dmem_responder (DEPTH_WORDS=1024, WAIT_STATES=2,
// BASE_ADDR=32'h2000): stores, loads, errors, back-pressure and mid-flight reset.
module tb_risky_dmem_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    risky_dmem_responder_if bus_if ();

    risky_dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (2),
        .BASE_ADDR   (32'h0000_2000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for rsp_valid, counting edges after the accept edge; bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (bus_if.rsp_valid !== 1'b1 && lat < 32) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One full transaction; returns data/err seen during RESP and the latency.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata,
                          output logic err, output int lat);
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_be    = be;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        wait_rsp(lat);
        rdata = bus_if.rsp_rdata;
        err   = bus_if.rsp_err;
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 32'h0000_0000;
        bus_if.req_wdata = 32'h0000_0000;
        bus_if.req_be    = 4'h0;
        bus_if.rsp_ready = 1'b0;

        // Reset for two cycles
        @(negedge clk);
        @(negedge clk);
        check32("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        check32("rst_rsp_err",   {31'd0, bus_if.rsp_err},   32'd0);
        check32("rst_rsp_rdata", bus_if.rsp_rdata,          32'h0000_0000);
        check32("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        rst_n = 1'b1;

        // Store then load the first word; rsp_valid is registered on the commit
        // edge (accept+WAIT_STATES) and first sampled by the core one edge later
        do_txn(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        check32("st0_lat",   32'(lat), 32'd2);
        check32("st0_err",   {31'd0, er}, 32'd0);
        check32("st0_rdata", rd, 32'h0000_0000);
        check32("post_hs_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        check32("post_hs_rdata", bus_if.rsp_rdata, 32'h0000_0000);
        check32("post_hs_ready", {31'd0, bus_if.req_ready}, 32'd1);
        do_txn(1'b0, 32'h0000_2000, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("ld0_lat",   32'(lat), 32'd2);
        check32("ld0_rdata", rd, 32'hDEAD_BEEF);
        check32("ld0_err",   {31'd0, er}, 32'd0);

        // Partial-lane store merge
        do_txn(1'b1, 32'h0000_2004, 32'h1122_3344, 4'hF, rd, er, lat);
        do_txn(1'b1, 32'h0000_2004, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
        check32("st_be_err", {31'd0, er}, 32'd0);
        do_txn(1'b0, 32'h0000_2004, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("ld_merge", rd, 32'h11BB_33DD);

        // Error cases
        do_txn(1'b0, 32'h0000_2002, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("mis_err",   {31'd0, er}, 32'd1);
        check32("mis_rdata", rd, 32'h0000_0000);
        do_txn(1'b0, 32'h0000_3000, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("oor_err",   {31'd0, er}, 32'd1);
        check32("oor_rdata", rd, 32'h0000_0000);
        do_txn(1'b0, 32'h0000_1FFC, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("below_err", {31'd0, er}, 32'd1);
        do_txn(1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, rd, er, lat);
        check32("oor_st_err", {31'd0, er}, 32'd1);
        do_txn(1'b1, 32'h0000_2001, 32'h1234_5678, 4'hF, rd, er, lat);
        check32("mis_st_err", {31'd0, er}, 32'd1);
        do_txn(1'b0, 32'h0000_2000, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("ld_after_err", rd, 32'hDEAD_BEEF);

        // Last word is in range
        do_txn(1'b1, 32'h0000_2FFC, 32'h0BAD_C0DE, 4'hF, rd, er, lat);
        check32("last_st_err", {31'd0, er}, 32'd0);
        do_txn(1'b0, 32'h0000_2FFC, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("last_ld", rd, 32'h0BAD_C0DE);
        check32("last_ld_err", {31'd0, er}, 32'd0);

        // Store with no byte enables writes nothing
        do_txn(1'b1, 32'h0000_2000, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("be0_err", {31'd0, er}, 32'd0);
        do_txn(1'b0, 32'h0000_2000, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("be0_ld", rd, 32'hDEAD_BEEF);

        // Back-pressure: rsp_ready low for 5 cycles while a new request waits
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 32'h0000_2000;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_addr  = 32'h0000_2004;
        wait_rsp(lat);
        check32("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check32("bp_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
            check32("bp_rdata", bus_if.rsp_rdata, 32'hDEAD_BEEF);
            check32("bp_err",   {31'd0, bus_if.rsp_err}, 32'd0);
            check32("bp_ready", {31'd0, bus_if.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        check32("bp_hs_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        check32("bp_hs_ready", {31'd0, bus_if.req_ready}, 32'd1);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        check32("bp_accepted", {31'd0, bus_if.req_ready}, 32'd0);
        wait_rsp(lat);
        check32("bp2_lat",   32'(lat), 32'd2);
        check32("bp2_rdata", bus_if.rsp_rdata, 32'h11BB_33DD);
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;

        // Reset during WAIT discards an uncommitted store
        do_txn(1'b1, 32'h0000_2008, 32'h55AA_55AA, 4'hF, rd, er, lat);
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 32'h0000_2008;
        bus_if.req_wdata = 32'hCAFE_F00D;
        bus_if.req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check32("mid_rst_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check32("mid_rst_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 32'h0000_2008, 32'h0000_0000, 4'h0, rd, er, lat);
        check32("mid_rst_ld", rd, 32'h55AA_55AA);
        check32("mid_rst_lat", 32'(lat), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
